// File: rtl/l1_mau_arb_if.sv
// Bundle of the L1 I/D request ports and the shared MAU port.
// slave = arbiter view, master = cache/memory environment view.
interface l1_mau_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4,
    parameter int LINE_W = 128
) ();
    logic              l1i_req_val;
    logic [ADDR_W-1:0] l1i_req_addr;
    logic              l1i_req_ack;
    logic [LINE_W-1:0] l1i_ack_data;

    logic              l1d_req_val;
    logic              l1d_req_nc;
    logic              l1d_req_we;
    logic [ADDR_W-1:0] l1d_req_addr;
    logic [DATA_W-1:0] l1d_req_wdata;
    logic [BE_W-1:0]   l1d_req_be;
    logic              l1d_req_ack;
    logic              l1d_ack_nc;
    logic              l1d_ack_we;
    logic [LINE_W-1:0] l1d_ack_data;

    logic              mem_req_val;
    logic              mem_req_nc;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [BE_W-1:0]   mem_req_be;
    logic              mem_req_ack;
    logic [LINE_W-1:0] mem_ack_data;

    modport slave (
        input  l1i_req_val, l1i_req_addr,
        output l1i_req_ack, l1i_ack_data,
        input  l1d_req_val, l1d_req_nc, l1d_req_we, l1d_req_addr, l1d_req_wdata, l1d_req_be,
        output l1d_req_ack, l1d_ack_nc, l1d_ack_we, l1d_ack_data,
        output mem_req_val, mem_req_nc, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
        input  mem_req_ack, mem_ack_data
    );

    modport master (
        output l1i_req_val, l1i_req_addr,
        input  l1i_req_ack, l1i_ack_data,
        output l1d_req_val, l1d_req_nc, l1d_req_we, l1d_req_addr, l1d_req_wdata, l1d_req_be,
        input  l1d_req_ack, l1d_ack_nc, l1d_ack_we, l1d_ack_data,
        input  mem_req_val, mem_req_nc, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
        output mem_req_ack, mem_ack_data
    );
endinterface

// File: rtl/l1_mau_arb.sv
// I/D L1 arbiter for the single MAU port, one outstanding transaction.
// L1_MAU_ARB_RR_EN selects round-robin tie breaking; default is D-cache priority.
module l1_mau_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4,
    parameter int LINE_W = 128
) (
    input logic          clk,
    input logic          rst_n,
    l1_mau_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_d;
    logic              grant_d;
    logic              capture;
    logic              i_ack;
    logic              d_ack;

    logic              req_nc;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;

    always_comb begin
        grant_d = 1'b0;
`ifdef L1_MAU_ARB_RR_EN
        // On a tie the requester that did not win last time goes first.
        if (bus.l1d_req_val && bus.l1i_req_val)
            grant_d = ~last_d;
        else
            grant_d = bus.l1d_req_val;
`else
        grant_d = bus.l1d_req_val;
`endif
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.l1i_req_val || bus.l1d_req_val) begin
                    capture   = 1'b1;
                    state_nxt = grant_d ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I: begin
                if (bus.mem_req_ack) begin
                    i_ack     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BUSY_D: begin
                if (bus.mem_req_ack) begin
                    d_ack     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_d <= 1'b1;
        end else begin
            state <= state_nxt;
            if (capture)
                last_d <= grant_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_nc    <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
        end else if (capture) begin
            if (grant_d) begin
                req_nc    <= bus.l1d_req_nc;
                req_we    <= bus.l1d_req_we;
                req_addr  <= bus.l1d_req_addr;
                req_wdata <= bus.l1d_req_wdata;
                req_be    <= bus.l1d_req_be;
            end else begin
                req_nc    <= 1'b0;
                req_we    <= 1'b0;
                req_addr  <= bus.l1i_req_addr;
                req_wdata <= '0;
                req_be    <= '1;
            end
        end
    end

    assign bus.mem_req_val   = (state != IDLE);
    assign bus.mem_req_nc    = req_nc;
    assign bus.mem_req_we    = req_we;
    assign bus.mem_req_addr  = req_addr;
    assign bus.mem_req_wdata = req_wdata;
    assign bus.mem_req_be    = req_be;

    assign bus.l1i_req_ack   = i_ack;
    assign bus.l1i_ack_data  = bus.mem_ack_data;
    assign bus.l1d_req_ack   = d_ack;
    assign bus.l1d_ack_nc    = req_nc;
    assign bus.l1d_ack_we    = req_we;
    assign bus.l1d_ack_data  = bus.mem_ack_data;

    // The owner must hold val until its ack; dropping it early is a protocol error.
    a_i_holds_val: assert property (@(posedge clk) disable iff (!rst_n)
        (state == BUSY_I) |-> bus.l1i_req_val);
    a_d_holds_val: assert property (@(posedge clk) disable iff (!rst_n)
        (state == BUSY_D) |-> bus.l1d_req_val);
    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.mem_req_val && !bus.mem_req_ack) |=>
            ($stable(req_nc) && $stable(req_we) && $stable(req_addr) &&
             $stable(req_wdata) && $stable(req_be)));
    a_one_ack: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_ack && d_ack));
    a_last_grant: assert property (@(posedge clk) disable iff (!rst_n)
        capture |=> (last_d == $past(grant_d)));

endmodule

// File: tb/tb_l1_mau_arb.sv
// Self-checking bench for l1_mau_arb: vector table plus scoreboard of expected
// MAU transactions in grant order; define L1_MAU_ARB_RR_EN for the round-robin build.
module tb_l1_mau_arb;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int LINE_W = 128;

    typedef struct {
        logic        d;
        logic        nc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
    } vec_t;

    typedef struct {
        logic        d;
        logic        nc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l1_mau_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .LINE_W(LINE_W)) bus ();

    l1_mau_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .LINE_W(LINE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   ack_lat = 0;
    logic mem_auto = 1'b1;
    logic force_ack = 1'b0;
    exp_t exp_q[$];
    exp_t cur;
    logic in_txn = 1'b0;
    int   grant_cyc = 0;
    int   ack_cyc = 0;
    int   i_acks = 0;
    int   d_acks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk_exp(input vec_t v);
        exp_t e;
        e.d    = v.d;
        e.addr = v.addr;
        if (v.d) begin
            e.nc = v.nc; e.we = v.we; e.wdata = v.wdata; e.be = v.be;
        end else begin
            e.nc = 1'b0; e.we = 1'b0; e.wdata = 32'h0; e.be = 4'hF;
        end
        return e;
    endfunction

    // Memory model: acks ack_lat cycles after the first mem_req_val cycle.
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_req_ack  = 1'b0;
        bus.mem_ack_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_auto) begin
                bus.mem_req_ack = force_ack;
                cnt = 0;
            end else if (bus.mem_req_val) begin
                if (cnt >= ack_lat) begin
                    bus.mem_req_ack  = 1'b1;
                    bus.mem_ack_data = {$urandom(), $urandom(), $urandom(), $urandom()};
                    cnt = 0;
                end else begin
                    bus.mem_req_ack = 1'b0;
                    cnt++;
                end
            end else begin
                bus.mem_req_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    // Scoreboard monitor: pops the expected transaction at each new grant.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_txn = 1'b0;
            end else begin
                if (bus.mem_req_val) begin
                    if (!in_txn) begin
                        if (exp_q.size() == 0)
                            chk("unexpected_grant", exp_q.size(), 1);
                        else
                            cur = exp_q.pop_front();
                        in_txn = 1'b1;
                        grant_cyc = cyc;
                    end
                    chk("mem_fields",
                        {bus.mem_req_nc, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_be},
                        {cur.nc, cur.we, cur.addr, cur.wdata, cur.be});
                end
                if (bus.mem_req_ack && in_txn) begin
                    chk("ack_route", {bus.l1i_req_ack, bus.l1d_req_ack}, {!cur.d, cur.d});
                    chk("ack_data", {bus.l1i_ack_data ^ bus.mem_ack_data, bus.l1d_ack_data ^ bus.mem_ack_data}, '0);
                    if (cur.d)
                        chk("ack_nc_we", {bus.l1d_ack_nc, bus.l1d_ack_we}, {cur.nc, cur.we});
                    if (cur.d) d_acks++; else i_acks++;
                    ack_cyc = cyc;
                    in_txn = 1'b0;
                end else begin
                    chk("no_ack", {bus.l1i_req_ack, bus.l1d_req_ack}, 2'b00);
                end
            end
        end
    end

    task automatic start_req(input vec_t v);
        if (v.d) begin
            bus.l1d_req_val   = 1'b1;
            bus.l1d_req_nc    = v.nc;
            bus.l1d_req_we    = v.we;
            bus.l1d_req_addr  = v.addr;
            bus.l1d_req_wdata = v.wdata;
            bus.l1d_req_be    = v.be;
        end else begin
            bus.l1i_req_val  = 1'b1;
            bus.l1i_req_addr = v.addr;
            if (!bus.l1d_req_val) begin
                // Idle D lines carry junk that must not leak into an I capture.
                bus.l1d_req_nc    = v.nc;
                bus.l1d_req_we    = v.we;
                bus.l1d_req_wdata = v.wdata;
                bus.l1d_req_be    = v.be;
            end
        end
    endtask

    task automatic wait_ack(input logic d);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            done = d ? bus.l1d_req_ack : bus.l1i_req_ack;
        end
        chk(d ? "d_ack_timeout" : "i_ack_timeout", done, 1'b1);
        @(posedge clk);
        #1;
        if (d) bus.l1d_req_val = 1'b0; else bus.l1i_req_val = 1'b0;
    endtask

    function automatic logic [127:0] out_vec();
        return {bus.mem_req_val, bus.mem_req_nc, bus.mem_req_we, bus.mem_req_addr,
                bus.mem_req_wdata, bus.mem_req_be, bus.l1i_req_ack, bus.l1d_req_ack,
                bus.l1d_ack_nc, bus.l1d_ack_we};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vec_t vi1, vi2, vd1, vd2, vx;
        int start, i0, d0, first_ack;

        vecs[0] = '{1'b0, 1'b1, 1'b1, 32'h0000_1040, 32'hAAAA_5555, 4'h5, 3};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 4'h3, 0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_0000, 4'hF, 1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h0000_4080, 32'h0000_0000, 4'h0, 0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 4'hC, 2};

        bus.l1i_req_val = 1'b0; bus.l1i_req_addr = '0;
        bus.l1d_req_val = 1'b0; bus.l1d_req_nc = 1'b0; bus.l1d_req_we = 1'b0;
        bus.l1d_req_addr = '0; bus.l1d_req_wdata = '0; bus.l1d_req_be = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", out_vec(), '0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            ack_lat = vecs[i].lat;
            @(posedge clk);
            #1;
            start = cyc;
            i0 = i_acks;
            d0 = d_acks;
            exp_q.push_back(mk_exp(vecs[i]));
            start_req(vecs[i]);
            wait_ack(vecs[i].d);
            chk("grant_lat", grant_cyc - start, 1);
            chk("ack_lat", ack_cyc - grant_cyc, vecs[i].lat);
            chk("idle_after_ack", {cyc - ack_cyc, 31'd0, bus.mem_req_val}, {32'd1, 32'd0});
            chk("ack_count", {i_acks - i0, d_acks - d0}, vecs[i].d ? {32'd0, 32'd1} : {32'd1, 32'd0});
        end

        // New D requests while I owns the bus must not disturb mem_req_*.
        ack_lat = 4;
        vi1 = '{1'b0, 1'b0, 1'b0, 32'h0000_5000, 32'h0, 4'h0, 0};
        vd1 = '{1'b1, 1'b0, 1'b1, 32'h0000_6000, 32'hCAFE_F00D, 4'h9, 0};
        vd2 = vd1;
        vd2.addr = 32'h0000_6100;
        @(posedge clk);
        #1;
        exp_q.push_back(mk_exp(vi1));
        exp_q.push_back(mk_exp(vd2));
        fork
            begin start_req(vi1); wait_ack(1'b0); end
            begin
                @(posedge clk); #1;
                start_req(vd1);
                @(posedge clk); #1;
                bus.l1d_req_addr = vd2.addr;
                wait_ack(1'b1);
            end
        join

        // Back-to-back D: second grant two cycles after the first ack.
        ack_lat = 1;
        vd1 = '{1'b1, 1'b0, 1'b0, 32'h0000_7000, 32'h0, 4'hF, 0};
        vd2 = '{1'b1, 1'b1, 1'b0, 32'h0000_7040, 32'h0, 4'h1, 0};
        @(posedge clk);
        #1;
        exp_q.push_back(mk_exp(vd1));
        exp_q.push_back(mk_exp(vd2));
        start_req(vd1);
        wait_ack(1'b1);
        first_ack = ack_cyc;
        start_req(vd2);
        wait_ack(1'b1);
        chk("b2b_gap", grant_cyc - first_ack, 2);

        // Asynchronous reset in BUSY_D, then a stale memory ack.
        ack_lat = 10;
        vx = '{1'b1, 1'b1, 1'b1, 32'h0000_8008, 32'h5A5A_A5A5, 4'h6, 0};
        @(posedge clk);
        #1;
        exp_q.push_back(mk_exp(vx));
        start_req(vx);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_before_reset", bus.mem_req_val, 1'b1);
        mem_auto = 1'b0;
        force_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", out_vec(), '0);
        bus.l1d_req_val = 1'b0;
        i0 = i_acks;
        d0 = d_acks;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        chk("stale_ack_seen", bus.mem_req_ack, 1'b1);
        chk("stale_ack_ignored", {bus.l1d_req_ack, bus.l1i_req_ack, bus.mem_req_val}, 3'b000);
        force_ack = 1'b0;
        @(negedge clk);
        mem_auto = 1'b1;
        chk("stale_ack_count", {i_acks - i0, d_acks - d0}, '0);
        chk("stale_sb_empty", exp_q.size(), 0);

        // Tie from reset state, each side issuing two back-to-back requests.
        ack_lat = 1;
        vi1 = '{1'b0, 1'b0, 1'b0, 32'h0000_9000, 32'h0, 4'h0, 0};
        vi2 = '{1'b0, 1'b0, 1'b0, 32'h0000_9040, 32'h0, 4'h0, 0};
        vd1 = '{1'b1, 1'b0, 1'b0, 32'h0000_A000, 32'h0, 4'hF, 0};
        vd2 = '{1'b1, 1'b0, 1'b1, 32'h0000_A004, 32'h0BAD_CAFE, 4'h2, 0};
        @(posedge clk);
        #1;
`ifdef L1_MAU_ARB_RR_EN
        exp_q.push_back(mk_exp(vi1));
        exp_q.push_back(mk_exp(vd1));
        exp_q.push_back(mk_exp(vi2));
        exp_q.push_back(mk_exp(vd2));
`else
        exp_q.push_back(mk_exp(vd1));
        exp_q.push_back(mk_exp(vd2));
        exp_q.push_back(mk_exp(vi1));
        exp_q.push_back(mk_exp(vi2));
`endif
        i0 = i_acks;
        d0 = d_acks;
        fork
            begin start_req(vi1); wait_ack(1'b0); start_req(vi2); wait_ack(1'b0); end
            begin start_req(vd1); wait_ack(1'b1); start_req(vd2); wait_ack(1'b1); end
        join
        chk("tie_counts", {i_acks - i0, d_acks - d0}, {32'd2, 32'd2});
        chk("final_sb_empty", exp_q.size(), 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
